// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe turn controller: cell encoding,
// controller states and a one-hot test used on the player cell selections.
package ttt_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_MOVE,
        ST_COMMIT,
        ST_GAME_OVER
    } ctrl_state_t;

    // Zero-hot and multi-hot selections both count as malformed moves.
    function automatic logic is_one_hot(input logic [NUM_CELLS-1:0] v);
        return (v != '0) && ((v & (v - NUM_CELLS'(1))) == '0);
    endfunction

endpackage

// File: rtl/first_empty_cell.sv
// Priority encoder over the packed board: one-hot marker of the lowest-indexed
// empty cell (pos1 wins), plus a flag when no cell is empty.
module first_empty_cell
    import ttt_pkg::*;
(
    input  logic [2*NUM_CELLS-1:0] cells,
    output logic [NUM_CELLS-1:0]   first_empty,
    output logic                   none_empty
);

    logic [NUM_CELLS-1:0] empty_mask;

    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_empty
        assign empty_mask[gi] = (cells[2*gi +: 2] == CELL_EMPTY);
    end

    // Isolating the lowest set bit gives pos1 the highest priority.
    assign first_empty = empty_mask & ~(empty_mask - NUM_CELLS'(1));
    assign none_empty  = (empty_mask == '0);

endmodule

// File: rtl/move_commit_controller.sv
// Turn/board controller: owns the board feeding illegal_move_checker, gates the
// active player's selection to it, commits legal moves and auto-places on timeout.
module move_commit_controller
    import ttt_pkg::*;
#(
    parameter int TURN_CYCLES = 750000000,
    parameter int CNT_W       = $clog2(TURN_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [8:0] player1_enabler,
    input  logic [8:0] player2_enabler,
    input  logic       confirm,
    input  logic       illegal,
    input  logic       win_detected,
    output logic [8:0] chk_p1_enabler,
    output logic [8:0] chk_p2_enabler,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       turn,
    output logic [3:0] moves_made,
    output logic       illegal_flag,
    output logic       timeout_flag,
    output logic       game_over,
    output logic       busy
);

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TURN_CYCLES - 1);

    ctrl_state_t                state_q, state_d;
    logic [2*NUM_CELLS-1:0]     board_q, board_d;
    logic                       turn_q, turn_d;
    logic [3:0]                 moves_q, moves_d;
    logic [CNT_W-1:0]           timer_q, timer_d;
    logic [NUM_CELLS-1:0]       cell_q, cell_d;
    logic                       illegal_flag_q, illegal_flag_d;
    logic                       timeout_flag_q, timeout_flag_d;

    logic [NUM_CELLS-1:0]       active_sel;
    logic [NUM_CELLS-1:0]       auto_cell;
    logic                       no_empty_cell;
    logic                       legal;
    logic                       timed_out;

    first_empty_cell u_first_empty (
        .cells       (board_q),
        .first_empty (auto_cell),
        .none_empty  (no_empty_cell)
    );

    assign active_sel = turn_q ? player2_enabler : player1_enabler;
    assign legal      = confirm && is_one_hot(active_sel) && !illegal;
    assign timed_out  = (timer_q == TIMER_LAST);

    always_comb begin
        state_d        = state_q;
        board_d        = board_q;
        turn_d         = turn_q;
        moves_d        = moves_q;
        timer_d        = timer_q;
        cell_d         = cell_q;
        illegal_flag_d = 1'b0;
        timeout_flag_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start) begin
                    board_d = '0;
                    turn_d  = 1'b0;
                    moves_d = 4'd0;
                    timer_d = '0;
                    state_d = ST_WAIT_MOVE;
                end
            end

            ST_WAIT_MOVE: begin
                if (win_detected) begin
                    state_d = ST_GAME_OVER;
                end else begin
                    timer_d = timed_out ? timer_q : timer_q + 1'b1;
                    if (legal) begin
                        cell_d  = active_sel;
                        state_d = ST_COMMIT;
                    end else begin
                        illegal_flag_d = confirm;
                        // A rejected confirm on the last cycle still lets the auto-placement through.
                        if (timed_out && !no_empty_cell) begin
                            cell_d         = auto_cell;
                            timeout_flag_d = 1'b1;
                            state_d        = ST_COMMIT;
                        end
                    end
                end
            end

            ST_COMMIT: begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    if (cell_q[i]) begin
                        board_d[2*i +: 2] = turn_q ? CELL_P2 : CELL_P1;
                    end
                end
                moves_d = moves_q + 4'd1;
                turn_d  = ~turn_q;
                timer_d = '0;
                state_d = (moves_q == 4'd8) ? ST_GAME_OVER : ST_WAIT_MOVE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            board_q        <= '0;
            turn_q         <= 1'b0;
            moves_q        <= 4'd0;
            timer_q        <= '0;
            cell_q         <= '0;
            illegal_flag_q <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            board_q        <= board_d;
            turn_q         <= turn_d;
            moves_q        <= moves_d;
            timer_q        <= timer_d;
            cell_q         <= cell_d;
            illegal_flag_q <= illegal_flag_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    // The idle player's selection is masked so it can never provoke illegal.
    assign chk_p1_enabler = turn_q ? '0 : player1_enabler;
    assign chk_p2_enabler = turn_q ? player2_enabler : '0;

    assign pos1 = board_q[1:0];
    assign pos2 = board_q[3:2];
    assign pos3 = board_q[5:4];
    assign pos4 = board_q[7:6];
    assign pos5 = board_q[9:8];
    assign pos6 = board_q[11:10];
    assign pos7 = board_q[13:12];
    assign pos8 = board_q[15:14];
    assign pos9 = board_q[17:16];

    assign turn         = turn_q;
    assign moves_made   = moves_q;
    assign illegal_flag = illegal_flag_q;
    assign timeout_flag = timeout_flag_q;
    assign game_over    = (state_q == ST_GAME_OVER);
    assign busy         = (state_q == ST_WAIT_MOVE) || (state_q == ST_COMMIT);

endmodule

// File: tb/tb_move_commit_controller.sv
// Self-checking bench for move_commit_controller: scripted game vectors, timeout
// and end-of-game sequences, then random play against a game-level reference model.
module tb_move_commit_controller;

    localparam int TC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] player1_enabler;
    logic [8:0] player2_enabler;
    logic       confirm;
    logic       illegal;
    logic       win_detected;
    logic [8:0] chk_p1_enabler;
    logic [8:0] chk_p2_enabler;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic       turn;
    logic [3:0] moves_made;
    logic       illegal_flag;
    logic       timeout_flag;
    logic       game_over;
    logic       busy;

    int total = 0;
    int bad   = 0;

    move_commit_controller #(.TURN_CYCLES(TC)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .player1_enabler (player1_enabler),
        .player2_enabler (player2_enabler),
        .confirm         (confirm),
        .illegal         (illegal),
        .win_detected    (win_detected),
        .chk_p1_enabler  (chk_p1_enabler),
        .chk_p2_enabler  (chk_p2_enabler),
        .pos1            (pos1),
        .pos2            (pos2),
        .pos3            (pos3),
        .pos4            (pos4),
        .pos5            (pos5),
        .pos6            (pos6),
        .pos7            (pos7),
        .pos8            (pos8),
        .pos9            (pos9),
        .turn            (turn),
        .moves_made      (moves_made),
        .illegal_flag    (illegal_flag),
        .timeout_flag    (timeout_flag),
        .game_over       (game_over),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (game rules, not hardware states) ----
    int  m_board[9];
    bit  m_play;
    bit  m_over;
    int  m_pend;
    int  m_elapsed;
    bit  m_turn;
    int  m_moves;
    bit  m_ill;
    bit  m_to;

    function automatic void model_reset();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_play = 0; m_over = 0; m_pend = -1; m_elapsed = 0;
        m_turn = 0; m_moves = 0; m_ill = 0; m_to = 0;
    endfunction

    function automatic logic [17:0] model_board();
        logic [17:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) r[2*i +: 2] = 2'(m_board[i]);
        return r;
    endfunction

    function automatic logic [8:0] occupied_mask();
        logic [8:0] r;
        for (int i = 0; i < 9; i++) r[i] = (m_board[i] != 0);
        return r;
    endfunction

    function automatic void model_step(input logic s, input logic [8:0] a,
                                       input logic [8:0] b, input logic c,
                                       input logic ill, input logic w);
        logic [8:0] sel;
        m_ill = 0;
        m_to  = 0;
        if (m_pend >= 0) begin
            m_board[m_pend] = m_turn ? 2 : 1;
            m_moves++;
            m_turn    = !m_turn;
            m_elapsed = 0;
            m_pend    = -1;
            if (m_moves == 9) begin m_play = 0; m_over = 1; end
        end else if (m_play) begin
            if (w) begin
                m_play = 0; m_over = 1;
            end else begin
                sel = m_turn ? b : a;
                if (c && $countones(sel) == 1 && !ill) begin
                    for (int i = 0; i < 9; i++) if (sel[i]) m_pend = i;
                end else begin
                    m_ill = c;
                    if (m_elapsed == TC - 1) begin
                        for (int i = 8; i >= 0; i--) if (m_board[i] == 0) m_pend = i;
                        m_to = 1;
                    end else begin
                        m_elapsed++;
                    end
                end
            end
        end else if (s) begin
            for (int i = 0; i < 9; i++) m_board[i] = 0;
            m_turn = 0; m_moves = 0; m_elapsed = 0; m_play = 1; m_over = 0;
        end
    endfunction

    // ---------------- checking helpers --------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] dut_board();
        return {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
    endfunction

    task automatic compare_all();
        chk("board",        32'(dut_board()),  32'(model_board()));
        chk("turn",         32'(turn),         32'(m_turn));
        chk("moves_made",   32'(moves_made),   32'(m_moves));
        chk("illegal_flag", 32'(illegal_flag), 32'(m_ill));
        chk("timeout_flag", 32'(timeout_flag), 32'(m_to));
        chk("game_over",    32'(game_over),    32'(m_over));
        chk("busy",         32'(busy),         32'(m_play));
    endtask

    task automatic cyc(input logic s, input logic [8:0] a, input logic [8:0] b,
                       input logic c, input logic ill, input logic w);
        @(negedge clk);
        start = s; player1_enabler = a; player2_enabler = b;
        confirm = c; illegal = ill; win_detected = w;
        #1;
        chk("chk_p1_enabler", 32'(chk_p1_enabler), 32'(m_turn ? 9'd0 : a));
        chk("chk_p2_enabler", 32'(chk_p2_enabler), 32'(m_turn ? b : 9'd0));
        @(posedge clk);
        model_step(s, a, b, c, ill, w);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic move(input logic pl, input logic [8:0] sel);
        cyc(1'b0, pl ? 9'd0 : sel, pl ? sel : 9'd0, 1'b1, 1'b0, 1'b0);
        idle();
    endtask

    typedef struct {
        logic        pl;
        logic [8:0]  sel;
        logic        ill;
        logic        exp_ill;
        logic [17:0] exp_board;
        logic        exp_turn;
        logic [3:0]  exp_moves;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int seen;
        int waited;
        logic [8:0] a, b, sel;
        logic s, c, ill, w;

        vecs[0] = '{1'b0, 9'h010, 1'b0, 1'b0, 18'h00100, 1'b1, 4'd1};
        vecs[1] = '{1'b1, 9'h001, 1'b0, 1'b0, 18'h00102, 1'b0, 4'd2};
        vecs[2] = '{1'b0, 9'h010, 1'b1, 1'b1, 18'h00102, 1'b0, 4'd2};
        vecs[3] = '{1'b0, 9'h003, 1'b0, 1'b1, 18'h00102, 1'b0, 4'd2};

        rst = 1'b1; start = 0; player1_enabler = 0; player2_enabler = 0;
        confirm = 0; illegal = 0; win_detected = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a game with three moves on the board.
        cyc(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
        move(1'b0, 9'h001);
        move(1'b1, 9'h002);
        move(1'b0, 9'h004);
        chk("pre_reset_moves", 32'(moves_made), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_reset_busy", 32'(busy), 32'd0);
        $display("reset mid-game: board=%05h moves=%0d turn=%0d", dut_board(), moves_made, turn);

        // Scripted moves: two legal commits, then a checker-rejected and a multi-hot confirm.
        cyc(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, vecs[i].pl ? 9'd0 : vecs[i].sel, vecs[i].pl ? vecs[i].sel : 9'd0,
                1'b1, vecs[i].ill, 1'b0);
            chk("vec_illegal_flag", 32'(illegal_flag), 32'(vecs[i].exp_ill));
            idle();
            chk("vec_board", 32'(dut_board()), 32'(vecs[i].exp_board));
            chk("vec_turn",  32'(turn),        32'(vecs[i].exp_turn));
            chk("vec_moves", 32'(moves_made),  32'(vecs[i].exp_moves));
            $display("vec %0d: player=%0d sel=%03h ill=%0d -> board=%05h turn=%0d moves=%0d",
                     i, vecs[i].pl + 1, vecs[i].sel, vecs[i].ill, dut_board(), turn, moves_made);
        end

        // P1 idles (P2 selection must stay masked) until auto-placement fills pos2.
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            cyc(1'b0, 9'd0, 9'h100, 1'b0, 1'b0, 1'b0);
            chk("masked_p2", 32'(chk_p2_enabler), 32'd0);
            if (timeout_flag) seen = 1;
        end
        chk("p1_timeout_seen", 32'(seen), 32'd1);
        idle();
        chk("p1_timeout_board", 32'(dut_board()), 32'h00106);
        chk("p1_timeout_turn", 32'(turn), 32'd1);
        $display("p1 timeout: board=%05h turn=%0d moves=%0d", dut_board(), turn, moves_made);

        // Timer restarts: P2 times out after exactly TC idle cycles.
        waited = 0;
        for (int k = 1; k <= 20 && waited == 0; k++) begin
            idle();
            if (timeout_flag) waited = k;
        end
        chk("p2_timeout_latency", 32'(waited), 32'(TC));
        idle();
        chk("p2_timeout_board", 32'(dut_board()), 32'h00126);
        $display("p2 timeout after %0d cycles: board=%05h", waited, dut_board());

        // Legal confirm on the last allowed cycle beats the timeout.
        repeat (TC - 1) idle();
        cyc(1'b0, 9'h100, 9'd0, 1'b1, 1'b0, 1'b0);
        chk("confirm_at_limit_no_timeout", 32'(timeout_flag), 32'd0);
        idle();
        chk("confirm_at_limit_board", 32'(dut_board()), 32'h10126);
        chk("confirm_at_limit_moves", 32'(moves_made), 32'd5);
        $display("confirm at limit: board=%05h moves=%0d", dut_board(), moves_made);

        // Win after move 5 ends the game; confirms are then ignored.
        cyc(1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1);
        chk("win_game_over", 32'(game_over), 32'd1);
        cyc(1'b0, 9'd0, 9'h008, 1'b1, 1'b0, 1'b0);
        idle();
        chk("win_moves_hold", 32'(moves_made), 32'd5);
        $display("win: game_over=%0d moves=%0d", game_over, moves_made);

        // Full board without a win.
        cyc(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) move(1'(k % 2), 9'(1 << k));
        chk("full_game_over", 32'(game_over), 32'd1);
        chk("full_moves", 32'(moves_made), 32'd9);
        chk("full_board", 32'(dut_board()), 32'h19999);
        move(1'b1, 9'h001);
        chk("full_confirm_ignored", 32'(moves_made), 32'd9);
        cyc(1'b1, 9'd0, 9'd0, 1'b0, 1'b0, 1'b0);
        chk("restart_board", 32'(dut_board()), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        $display("full board: restart board=%05h busy=%0d", dut_board(), busy);

        // Random play against the reference model.
        for (int n = 0; n < 3000; n++) begin
            s = ($urandom % 4) == 0;
            c = ($urandom % 3) == 0;
            w = ($urandom % 50) == 0;
            case ($urandom % 10)
                0: a = 9'd0;
                1: a = 9'($urandom % 512);
                default: a = 9'(1 << ($urandom % 9));
            endcase
            case ($urandom % 10)
                0: b = 9'd0;
                1: b = 9'($urandom % 512);
                default: b = 9'(1 << ($urandom % 9));
            endcase
            sel = m_turn ? b : a;
            ill = ((sel & occupied_mask()) != 9'd0) || (($urandom % 10) == 0);
            cyc(s, a, b, c, ill, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_commit_controller.md
Name: move_commit_controller

Overview:
- Turn/board controller directly downstream of illegal_move_checker.
- Holds the 3x3 board registers that drive the checker's pos1..pos9 inputs.
- Routes only the active player's cell selection to the checker and commits legal moves.
- Alternates turns, enforces a per-turn timeout with auto-placement, and ends the game on win or full board.

Parameters:
TURN_CYCLES, 750000000, cycles allowed per turn before auto-placement (15 s at 50 MHz)
CNT_W, $clog2(TURN_CYCLES), turn timer width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  new-game request, level sampled
player1_enabler  in  9  player 1 cell select, one-hot, bit0=pos1
player2_enabler  in  9  player 2 cell select, one-hot
confirm  in  1  single-cycle move-confirm pulse from the active player
illegal  in  1  combinational result from illegal_move_checker
win_detected  in  1  from downstream win checker, evaluated on registered board
chk_p1_enabler  out  9  player1_enabler gated by turn==0, else 0; to checker
chk_p2_enabler  out  9  player2_enabler gated by turn==1, else 0; to checker
pos1..pos9  out  2 each  cell state: 00 empty, 01 player 1, 10 player 2 (11 never driven)
turn  out  1  0 = player 1, 1 = player 2
moves_made  out  4  committed moves, 0..9
illegal_flag  out  1  one-cycle pulse on a rejected confirm
timeout_flag  out  1  one-cycle pulse on auto-placement
game_over  out  1  high in GAME_OVER
busy  out  1  high in WAIT_MOVE or COMMIT

Behaviour:
- Reset (async, any state): state=IDLE, all pos=00, turn=0, moves_made=0, timer=0, all flags 0, latched cell=0.
- States: IDLE, WAIT_MOVE, COMMIT, GAME_OVER.
- IDLE:
  - start=1 -> clear board, turn=0, moves_made=0, timer=0, go to WAIT_MOVE.
- WAIT_MOVE:
  - timer increments each cycle.
  - Active enabler = turn ? player2_enabler : player1_enabler.
  - legal = confirm & exactly one bit set in active enabler & !illegal.
  - confirm & legal -> latch active enabler, go to COMMIT.
  - confirm & !legal -> illegal_flag=1 for one cycle; stay in WAIT_MOVE; timer not reset.
    - Zero-hot or multi-hot enabler is illegal.
  - No legal confirm and timer==TURN_CYCLES-1 -> latch lowest-indexed empty cell, timeout_flag=1 for one cycle, go to COMMIT.
  - Legal confirm and timeout in the same cycle: confirm wins, no timeout_flag.
  - Illegal confirm and timeout in the same cycle: both flags pulse; the auto-placement is committed.
  - win_detected=1 -> GAME_OVER. Highest priority in WAIT_MOVE.
- COMMIT (exactly one cycle):
  - Write the latched cell with turn?10:01.
  - moves_made+1, toggle turn, timer=0.
  - If the new moves_made==9 -> GAME_OVER, else WAIT_MOVE.
  - Confirm is ignored in COMMIT.
- GAME_OVER:
  - Board, turn and moves_made hold. game_over=1.
  - start=1 -> same clear as IDLE, go to WAIT_MOVE.
- start is ignored in WAIT_MOVE and COMMIT.
- Latency: legal confirm sampled at edge N -> COMMIT after N -> board, turn and moves_made updated at edge N+1 -> checker sees the new board from cycle N+1.
- The timeout path never selects an occupied cell. A full board cannot reach WAIT_MOVE (moves_made==9 forces GAME_OVER).
- chk_p*_enabler are combinational. The inactive player's selection never reaches the checker, so the opponent cannot raise illegal.
- Flags: registered; high only in the cycle after the triggering edge.
- Timer saturation: the timer never exceeds TURN_CYCLES-1.

Decomposition:
- Shared package ttt_pkg:
  - cell encoding constants CELL_EMPTY=2'b00, CELL_P1=2'b01, CELL_P2=2'b10
  - state enum ctrl_state_t
  - NUM_CELLS=9
- Sub-module first_empty_cell:
  - Combinational priority encoder over pos1..pos9.
  - Outputs a one-hot 9-bit result with pos1 highest priority, plus a none_empty bit.
  - Instantiated once for timeout placement.

Test Plan (TURN_CYCLES=8):
1. Reset mid-WAIT_MOVE with 3 moves on board -> next cycle all pos=00, moves_made=0, turn=0, state IDLE, flags 0.
2. start, P1 confirm with player1_enabler=9'h010, illegal=0 -> pos5=01 one cycle after COMMIT, turn=1, moves_made=1. Then P2 9'h001 -> pos1=10, turn=0.
3. After (2), P1 confirms 9'h010 with illegal=1 from the checker -> illegal_flag pulse, pos5 stays 01, turn=0. Repeat with 9'h003 and illegal=0 -> illegal_flag pulse (multi-hot), no commit.
4. P1 idle 8 cycles with pos1 occupied -> timeout_flag pulse, pos2=01, turn=1, timer restarts at 0. A legal confirm exactly at cycle 8 -> the confirmed cell is committed, no timeout_flag.
5. Nine alternating legal moves with win_detected=0 -> after the 9th commit game_over=1, moves_made=9, confirm ignored. start -> board cleared, WAIT_MOVE.
6. win_detected=1 in WAIT_MOVE after move 5 -> GAME_OVER next cycle. While turn=0, player2_enabler=9'h100 -> chk_p2_enabler=0.
